// File: rtl/riscv_multicycle_core.sv
// Multicycle RV32I/RV32E core: FETCH -> DECODE -> EXECUTE -> (MEM) -> WRITEBACK,
// one memory port with a valid/ready handshake, and a terminal HALT state on any fault.
module riscv_multicycle_core #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          NUM_REGS     = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam int         RW   = $clog2(NUM_REGS);
    localparam logic [5:0] NREG = 6'(NUM_REGS);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    state_t      state_q, state_d;
    logic        run_q, run_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] res_q, res_d;
    logic [31:0] addr_q, addr_d;

    logic [31:0] rf_q [NUM_REGS];
    logic [31:0] rs1v_q, rs2v_q;
    logic        rf_we;

    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;

    assign opc = ir_q[6:0];
    assign rd  = ir_q[11:7];
    assign f3  = ir_q[14:12];
    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign f7  = ir_q[31:25];

    // x0 is forced to zero at the read side so it never needs a write-protected entry.
    logic [31:0] rs1_val, rs2_val;
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rs1v_q;
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rs2v_q;

    logic        legal, use_rd, use_rs1, use_rs2, reg_bad, wb_en;
    logic [31:0] imm_c;

    always_comb begin
        legal   = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                legal  = 1'b1;
                use_rd = 1'b1;
            end
            OPC_JALR: begin
                legal   = (f3 == 3'd0);
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                legal   = (f3 != 3'd2) && (f3 != 3'd3);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                legal   = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_STORE: begin
                legal   = (f3 <= 3'd2);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                if (f3 == 3'd1)      legal = (f7 == 7'h00);
                else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
                else                 legal = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_OP: begin
                legal   = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_FENCE: legal = (f3 == 3'd0);
            default:   legal = 1'b0;
        endcase
        reg_bad = (use_rd  && ({1'b0, rd}  >= NREG)) ||
                  (use_rs1 && ({1'b0, rs1} >= NREG)) ||
                  (use_rs2 && ({1'b0, rs2} >= NREG));
        wb_en   = use_rd;

        case (opc)
            OPC_LUI, OPC_AUIPC: imm_c = {ir_q[31:12], 12'd0};
            OPC_JAL:    imm_c = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            OPC_BRANCH: imm_c = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            OPC_STORE:  imm_c = {{21{ir_q[31]}}, ir_q[30:25], ir_q[11:7]};
            default:    imm_c = {{21{ir_q[31]}}, ir_q[30:20]};
        endcase
    end

    logic [31:0] alu_b, alu_y, sum;
    logic        alu_sub, taken;

    always_comb begin
        alu_b   = (opc == OPC_OP) ? rs2_val : imm_q;
        alu_sub = (opc == OPC_OP) && ir_q[30];
        sum     = rs1_val + imm_q;
        alu_y   = 32'd0;
        case (f3)
            3'd0: alu_y = alu_sub ? (rs1_val - alu_b) : (rs1_val + alu_b);
            3'd1: alu_y = rs1_val << alu_b[4:0];
            3'd2: alu_y = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'd3: alu_y = {31'd0, rs1_val < alu_b};
            3'd4: alu_y = rs1_val ^ alu_b;
            3'd5: alu_y = ir_q[30] ? $unsigned($signed(rs1_val) >>> alu_b[4:0])
                                   : (rs1_val >> alu_b[4:0]);
            3'd6: alu_y = rs1_val | alu_b;
            3'd7: alu_y = rs1_val & alu_b;
            default: alu_y = 32'd0;
        endcase
        taken = 1'b0;
        case (f3)
            3'd0: taken = (rs1_val == rs2_val);
            3'd1: taken = (rs1_val != rs2_val);
            3'd4: taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'd5: taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'd6: taken = (rs1_val <  rs2_val);
            3'd7: taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

    logic [31:0] ld_shift, ld_val;

    always_comb begin
        ld_shift = mem_rdata >> {addr_q[1:0], 3'b000};
        case (f3)
            3'd0:    ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'd1:    ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'd4:    ld_val = {24'd0, ld_shift[7:0]};
            3'd5:    ld_val = {16'd0, ld_shift[15:0]};
            default: ld_val = mem_rdata;
        endcase
    end

    logic        is_mem, misaligned;
    logic [31:0] nxt;

    always_comb begin
        state_d    = state_q;
        run_d      = 1'b1;
        pc_d       = pc_q;
        ir_d       = ir_q;
        imm_d      = imm_q;
        npc_d      = npc_q;
        res_d      = res_q;
        addr_d     = addr_q;
        rf_we      = 1'b0;
        is_mem     = (opc == OPC_LOAD) || (opc == OPC_STORE);
        misaligned = ((f3[1:0] == 2'd1) && sum[0]) || ((f3[1:0] == 2'd2) && (sum[1:0] != 2'd0));
        nxt        = pc_q + 32'd4;
        case (state_q)
            S_FETCH: begin
                if (run_q && mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                imm_d   = imm_c;
                state_d = (legal && !reg_bad) ? S_EXECUTE : S_HALT;
            end
            S_EXECUTE: begin
                case (opc)
                    OPC_LUI:    res_d = imm_q;
                    OPC_AUIPC:  res_d = pc_q + imm_q;
                    OPC_JAL: begin
                        res_d = pc_q + 32'd4;
                        nxt   = pc_q + imm_q;
                    end
                    OPC_JALR: begin
                        res_d = pc_q + 32'd4;
                        nxt   = sum & ~32'd1;
                    end
                    OPC_BRANCH: if (taken) nxt = pc_q + imm_q;
                    OPC_LOAD, OPC_STORE: addr_d = sum;
                    OPC_OP, OPC_OPIMM:   res_d  = alu_y;
                    default: ;
                endcase
                npc_d = nxt;
                // Faults are caught here so no request is issued and retire never pulses.
                if (is_mem)
                    state_d = misaligned ? S_HALT : S_MEM;
                else
                    state_d = (nxt[1:0] != 2'd0) ? S_HALT : S_WRITEBACK;
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (opc == OPC_LOAD) res_d = ld_val;
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                rf_we   = wb_en && (rd != 5'd0);
                pc_d    = npc_q;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
            pc_q    <= RESET_VECTOR;
            ir_q    <= 32'd0;
            imm_q   <= 32'd0;
            npc_q   <= 32'd0;
            res_q   <= 32'd0;
            addr_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            npc_q   <= npc_d;
            res_q   <= res_d;
            addr_q  <= addr_d;
        end
    end

    // Register file has no reset so it maps onto RAM with a registered read port.
    always_ff @(posedge clk) begin
        if (rf_we) rf_q[rd[RW-1:0]] <= res_q;
        if (state_q == S_DECODE) begin
            rs1v_q <= rf_q[rs1[RW-1:0]];
            rs2v_q <= rf_q[rs2[RW-1:0]];
        end
    end

    logic [3:0] strb;

    always_comb begin
        case (f3[1:0])
            2'd0: begin
                strb      = 4'b0001 << addr_q[1:0];
                mem_wdata = {4{rs2_val[7:0]}};
            end
            2'd1: begin
                strb      = 4'b0011 << addr_q[1:0];
                mem_wdata = {2{rs2_val[15:0]}};
            end
            default: begin
                strb      = 4'b1111;
                mem_wdata = rs2_val;
            end
        endcase
    end

    assign mem_req   = run_q && ((state_q == S_FETCH) || (state_q == S_MEM));
    assign mem_we    = (state_q == S_MEM) && (opc == OPC_STORE);
    assign mem_addr  = (state_q == S_MEM) ? {addr_q[31:2], 2'b00} : pc_q;
    assign mem_wstrb = mem_we ? strb : 4'b0000;
    assign pc        = pc_q;
    assign retire    = (state_q == S_WRITEBACK);
    assign halted    = (state_q == S_HALT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core: small programs in a word memory with
// configurable wait states, results observed through stores and the core's outputs.
module tb_riscv_multicycle_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic [3:0]  mem_wstrb;
    logic [2:0]  dbg_state;

    logic        req16, we16, retire16, halted16;
    logic [31:0] addr16, wdata16, rdata16, pc16;
    logic [3:0]  wstrb16;
    logic [2:0]  st16;

    int checks = 0;
    int errors = 0;

    logic [31:0] init_mem [0:255];
    logic [31:0] mem      [0:255];
    int          wait_cfg = 0;
    int          wait_cnt;
    logic [31:0] last_fetch;
    int          retire_cnt, dreq_cnt, retire16_cnt;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JALR = 7'b1100111;
    localparam logic [6:0] LOAD = 7'b0000011, OPIMM = 7'b0010011, OP = 7'b0110011;
    localparam logic [31:0] ILLEGAL = 32'hFFFF_FFFF;
    localparam logic [31:0] ADDI_X15 = 32'h0010_0793;
    localparam logic [31:0] ADDI_X16 = 32'h0010_0813;

    always #5 clk = ~clk;

    riscv_multicycle_core dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc(pc), .retire(retire),
        .halted(halted), .dbg_state(dbg_state)
    );

    riscv_multicycle_core #(.NUM_REGS(16)) dut16 (
        .clk(clk), .reset(reset), .mem_req(req16), .mem_we(we16),
        .mem_addr(addr16), .mem_wdata(wdata16), .mem_wstrb(wstrb16),
        .mem_ready(req16), .mem_rdata(rdata16), .pc(pc16), .retire(retire16),
        .halted(halted16), .dbg_state(st16)
    );

    assign rdata16   = addr16[2] ? ADDI_X16 : ADDI_X15;
    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_ready = mem_req && (wait_cnt == 0);

    always @(posedge clk or posedge reset) begin
        if (reset)          wait_cnt <= wait_cfg;
        else if (mem_req)   wait_cnt <= mem_ready ? wait_cfg : wait_cnt - 1;
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
            retire_cnt   <= 0;
            dreq_cnt     <= 0;
            retire16_cnt <= 0;
            last_fetch   <= 32'hFFFF_FFFF;
        end else begin
            if (mem_req && mem_we && mem_ready)
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (mem_req && !mem_we && mem_ready && dbg_state == 3'd0) last_fetch <= mem_addr;
            if (retire)   retire_cnt   <= retire_cnt + 1;
            if (retire16) retire16_cnt <= retire16_cnt + 1;
            if (mem_req && dbg_state == 3'd3) dreq_cnt <= dreq_cnt + 1;
        end
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, 5'd0, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd0, 5'd0, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_prog;
        for (int i = 0; i < 256; i++) init_mem[i] = 32'd0;
    endtask

    task automatic start(input int w);
        wait_cfg = w;
        reset = 1'b1;
        step;
        step;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_halt(input int maxc);
        int n;
        n = 0;
        while (!halted && n < maxc) begin
            step;
            n++;
        end
        chk("halt_reached", halted, 1);
    endtask

    task automatic wait_state(input logic [2:0] s, input int maxc);
        int n;
        n = 0;
        while (dbg_state != s && n < maxc) begin
            step;
            n++;
        end
        chk("state_reached", dbg_state, s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rbits;
        logic       seen;

        // Basic ADDI/ADD program, reset state, retire timing, x0 write suppression
        clear_prog;
        init_mem[0]    = enc_i(12'h005, 5'd0, 3'd0, 5'd1, OPIMM);
        init_mem[1]    = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
        init_mem[2]    = enc_s(12'h100, 5'd2, 3'd2);
        init_mem[3]    = enc_i(12'h007, 5'd0, 3'd0, 5'd0, OPIMM);
        init_mem[4]    = enc_s(12'h104, 5'd0, 3'd2);
        init_mem[5]    = ILLEGAL;
        init_mem[8'h41] = 32'hDEAD_BEEF;
        wait_cfg = 0;
        reset = 1'b1;
        step;
        step;
        chk("rst_outputs", {mem_req, mem_we, mem_wstrb, retire, halted, dbg_state}, 0);
        chk("rst_pc", pc, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        rbits = 8'd0;
        for (int c = 1; c <= 8; c++) begin
            step;
            rbits[c-1] = retire;
            if (c == 1) chk("first_req", {mem_req, mem_addr}, {1'b1, 32'h0});
        end
        chk("retire_cycles", rbits, 8'h88);
        step;
        chk("pc_after_two", pc, 32'h8);
        run_halt(200);
        chk("halt_pc", pc, 32'h14);
        chk("add_result", mem[8'h40], 32'd10);
        chk("x0_reads_zero", mem[8'h41], 32'd0);
        chk("retire_count", retire_cnt, 5);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step;
            seen |= mem_req | retire;
        end
        chk("halt_quiet", {seen, pc}, {1'b0, 32'h14});

        // SB with three wait states: bus outputs held for four cycles
        clear_prog;
        init_mem[0] = enc_i(12'h0AB, 5'd0, 3'd0, 5'd3, OPIMM);
        init_mem[1] = enc_s(12'h002, 5'd3, 3'd0);
        init_mem[2] = ILLEGAL;
        start(3);
        wait_state(3'd3, 100);
        for (int k = 0; k < 4; k++) begin
            chk("sb_bus", {mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata[23:16], mem_ready},
                {1'b1, 1'b1, 4'b0100, 32'h0, 8'hAB, (k == 3)});
            if (k < 3) step;
        end
        run_halt(200);
        chk("sb_mem", mem[0], 32'h0AAB_0193);
        chk("sb_halt_pc", pc, 32'h8);

        // Loads with sign/zero extension, sub-word stores
        clear_prog;
        init_mem[8'h40] = 32'h0000_0080;
        init_mem[8'h41] = 32'h9A00_0000;
        init_mem[8'h42] = 32'h1122_3344;
        init_mem[0]  = enc_i(12'h100, 5'd0, 3'd0, 5'd4, LOAD);
        init_mem[1]  = enc_i(12'h100, 5'd0, 3'd4, 5'd5, LOAD);
        init_mem[2]  = enc_i(12'h107, 5'd0, 3'd0, 5'd6, LOAD);
        init_mem[3]  = enc_i(12'h106, 5'd0, 3'd5, 5'd7, LOAD);
        init_mem[4]  = enc_i(12'h106, 5'd0, 3'd1, 5'd8, LOAD);
        init_mem[5]  = {20'h12345, 5'd9, LUI};
        init_mem[6]  = enc_i(12'h678, 5'd9, 3'd0, 5'd9, OPIMM);
        init_mem[7]  = enc_s(12'h10A, 5'd9, 3'd1);
        init_mem[8]  = enc_s(12'h10D, 5'd9, 3'd0);
        init_mem[9]  = enc_s(12'h110, 5'd4, 3'd2);
        init_mem[10] = enc_s(12'h114, 5'd5, 3'd2);
        init_mem[11] = enc_s(12'h118, 5'd6, 3'd2);
        init_mem[12] = enc_s(12'h11C, 5'd7, 3'd2);
        init_mem[13] = enc_s(12'h120, 5'd8, 3'd2);
        init_mem[14] = ILLEGAL;
        start(0);
        run_halt(400);
        chk("ld_halt_pc", pc, 32'h38);
        chk("lb_80", mem[8'h44], 32'hFFFF_FF80);
        chk("lbu_80", mem[8'h45], 32'h0000_0080);
        chk("lb_lane3", mem[8'h46], 32'hFFFF_FF9A);
        chk("lhu_upper", mem[8'h47], 32'h0000_9A00);
        chk("lh_upper", mem[8'h48], 32'hFFFF_9A00);
        chk("sh_upper", mem[8'h42], 32'h5678_3344);
        chk("sb_lane1", mem[8'h43], 32'h0000_7800);

        // ALU: shifts, compares, subtract, shamt masking, AUIPC
        clear_prog;
        init_mem[8'h43] = 32'hFFFF_FFFF;
        init_mem[8'h47] = 32'hFFFF_FFFF;
        init_mem[0]  = enc_i(12'hFF0, 5'd0, 3'd0, 5'd1, OPIMM);
        init_mem[1]  = enc_i(12'h402, 5'd1, 3'd5, 5'd2, OPIMM);
        init_mem[2]  = enc_i(12'h01C, 5'd1, 3'd5, 5'd3, OPIMM);
        init_mem[3]  = enc_i(12'h000, 5'd1, 3'd2, 5'd4, OPIMM);
        init_mem[4]  = enc_i(12'h001, 5'd1, 3'd3, 5'd5, OPIMM);
        init_mem[5]  = enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd6);
        init_mem[6]  = enc_i(12'h021, 5'd0, 3'd0, 5'd8, OPIMM);
        init_mem[7]  = enc_r(7'h00, 5'd8, 5'd6, 3'd1, 5'd7);
        init_mem[8]  = enc_r(7'h00, 5'd6, 5'd1, 3'd2, 5'd10);
        init_mem[9]  = enc_r(7'h00, 5'd6, 5'd1, 3'd3, 5'd11);
        init_mem[10] = enc_i(12'h0FF, 5'd1, 3'd4, 5'd12, OPIMM);
        init_mem[11] = {20'h00001, 5'd13, AUIPC};
        init_mem[12] = enc_s(12'h100, 5'd2, 3'd2);
        init_mem[13] = enc_s(12'h104, 5'd3, 3'd2);
        init_mem[14] = enc_s(12'h108, 5'd4, 3'd2);
        init_mem[15] = enc_s(12'h10C, 5'd5, 3'd2);
        init_mem[16] = enc_s(12'h110, 5'd6, 3'd2);
        init_mem[17] = enc_s(12'h114, 5'd7, 3'd2);
        init_mem[18] = enc_s(12'h118, 5'd10, 3'd2);
        init_mem[19] = enc_s(12'h11C, 5'd11, 3'd2);
        init_mem[20] = enc_s(12'h120, 5'd12, 3'd2);
        init_mem[21] = enc_s(12'h124, 5'd13, 3'd2);
        init_mem[22] = ILLEGAL;
        start(0);
        run_halt(600);
        chk("srai", mem[8'h40], 32'hFFFF_FFFC);
        chk("srli", mem[8'h41], 32'h0000_000F);
        chk("slti", mem[8'h42], 32'd1);
        chk("sltiu", mem[8'h43], 32'd0);
        chk("sub", mem[8'h44], 32'd16);
        chk("sll_shamt5", mem[8'h45], 32'd32);
        chk("slt", mem[8'h46], 32'd1);
        chk("sltu", mem[8'h47], 32'd0);
        chk("xori", mem[8'h48], 32'hFFFF_FF0F);
        chk("auipc", mem[8'h49], 32'h0000_102C);

        // Taken BEQ backwards
        clear_prog;
        init_mem[0] = enc_j(21'h000020, 5'd1);
        init_mem[8] = enc_b(13'h1FF8, 3'd0);
        init_mem[6] = ILLEGAL;
        start(0);
        run_halt(200);
        chk("beq_fetch", last_fetch, 32'h18);
        chk("beq_pc", {pc, 32'(retire_cnt)}, {32'h18, 32'd2});

        // JALR, backward JAL, not-taken BNE
        clear_prog;
        init_mem[0]  = enc_i(12'h040, 5'd0, 3'd0, 5'd1, OPIMM);
        init_mem[1]  = enc_i(12'h001, 5'd1, 3'd0, 5'd2, JALR);
        init_mem[16] = enc_s(12'h100, 5'd2, 3'd2);
        init_mem[17] = enc_j(21'h1FFFDC, 5'd0);
        init_mem[8]  = enc_b(13'h1FF8, 3'd1);
        init_mem[9]  = ILLEGAL;
        start(0);
        run_halt(200);
        chk("jalr_link", mem[8'h40], 32'h8);
        chk("bne_fetch", last_fetch, 32'h24);
        chk("bne_pc", {pc, 32'(retire_cnt)}, {32'h24, 32'd5});

        // Misaligned LW: halt with no data request
        clear_prog;
        init_mem[0] = enc_i(12'h102, 5'd0, 3'd2, 5'd1, LOAD);
        start(0);
        run_halt(100);
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step;
            seen |= mem_req;
        end
        chk("lw_mis", {seen, pc, 32'(dreq_cnt), 32'(retire_cnt)}, {1'b0, 32'h0, 32'd0, 32'd0});

        // Misaligned SH: halt with no data request
        clear_prog;
        init_mem[0] = enc_s(12'h103, 5'd0, 3'd1);
        start(0);
        run_halt(100);
        chk("sh_mis", {pc, 32'(dreq_cnt)}, {32'h0, 32'd0});

        // JALR to a misaligned target: no retire, pc frozen; RV32E instance checked too
        clear_prog;
        init_mem[0] = enc_i(12'h006, 5'd0, 3'd0, 5'd1, OPIMM);
        init_mem[1] = enc_i(12'h000, 5'd1, 3'd0, 5'd0, JALR);
        start(0);
        run_halt(100);
        chk("jalr_mis", {pc, 32'(retire_cnt)}, {32'h4, 32'd1});
        chk("rv32e_x16", {halted16, req16, pc16, 32'(retire16_cnt)}, {2'b10, 32'h4, 32'd1});

        // Reset during a fetch wait
        clear_prog;
        init_mem[0] = enc_i(12'h001, 5'd0, 3'd0, 5'd1, OPIMM);
        init_mem[1] = enc_i(12'h002, 5'd0, 3'd0, 5'd2, OPIMM);
        init_mem[2] = ILLEGAL;
        start(5);
        wait_state(3'd4, 100);
        step;
        step;
        chk("fetch_wait", {mem_req, mem_ready, pc}, {2'b10, 32'h4});
        reset = 1'b1;
        #1;
        chk("rst_in_fetch", {pc, mem_req, retire, halted, dbg_state}, {32'h0, 6'd0});

        // Reset during a store wait
        clear_prog;
        init_mem[0] = enc_i(12'h055, 5'd0, 3'd0, 5'd3, OPIMM);
        init_mem[1] = enc_s(12'h100, 5'd3, 3'd2);
        start(5);
        wait_state(3'd3, 100);
        chk("sw_wait", {mem_we, mem_wstrb, mem_ready}, {1'b1, 4'hF, 1'b0});
        reset = 1'b1;
        #1;
        chk("rst_in_store", {mem_req, mem_we, mem_wstrb, pc}, {6'd0, 32'h0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
